// File: rtl/node_stream_if.sv
// NoC endpoint: buffers TB packets and serialises them MSB-first onto a FLIT_W link,
// reassembles inbound flit streams into an RX queue, and keeps per-node packet counters.
module node_stream_if #(
  parameter int NODEID    = 0,
  parameter int PKT_W     = 32,
  parameter int FLIT_W    = 8,
  parameter int TXQ_DEPTH = 4,
  parameter int RXQ_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [PKT_W-1:0]  pkt_in,
  input  logic              pkt_in_avail,
  output logic              cQ_full,
  output logic [PKT_W-1:0]  pkt_out,
  output logic              pkt_out_avail,
  input  logic              pkt_out_ready,
  input  logic              free_outbound,
  output logic              put_outbound,
  output logic [FLIT_W-1:0] payload_outbound,
  output logic              free_inbound,
  input  logic              put_inbound,
  input  logic [FLIT_W-1:0] payload_inbound,
  output logic [CNT_W-1:0]  tx_pkt_count,
  output logic [CNT_W-1:0]  rx_pkt_count,
  output logic [CNT_W-1:0]  drop_count
);

  localparam int NBEATS = PKT_W / FLIT_W;
  localparam int BEAT_W = $clog2(NBEATS);
  localparam int TXP_W  = (TXQ_DEPTH > 1) ? $clog2(TXQ_DEPTH) : 1;
  localparam int TXC_W  = $clog2(TXQ_DEPTH + 1);
  localparam int RXP_W  = (RXQ_DEPTH > 1) ? $clog2(RXQ_DEPTH) : 1;
  localparam int RXC_W  = $clog2(RXQ_DEPTH + 1);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);
  localparam logic [TXP_W-1:0]  TX_LAST   = TXP_W'(TXQ_DEPTH - 1);
  localparam logic [TXC_W-1:0]  TX_FULL   = TXC_W'(TXQ_DEPTH);
  localparam logic [RXP_W-1:0]  RX_LAST   = RXP_W'(RXQ_DEPTH - 1);
  localparam logic [RXC_W-1:0]  RX_FULL   = RXC_W'(RXQ_DEPTH);

  if ((PKT_W % FLIT_W) != 0 || NBEATS < 2 || TXQ_DEPTH < 1 || RXQ_DEPTH < 1 || NODEID < 0)
  begin : g_bad_params
    $error("node_stream_if: illegal parameter combination");
  end

  typedef enum logic [0:0] {TX_IDLE = 1'b0, TX_SEND = 1'b1} tx_state_e;
  typedef enum logic [0:0] {RX_IDLE = 1'b0, RX_RECV = 1'b1} rx_state_e;

  logic [PKT_W-1:0]  tx_mem_q [TXQ_DEPTH];
  logic [TXP_W-1:0]  tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [TXC_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic              tx_push, tx_pop, tx_full;
  logic [PKT_W-1:0]  tx_head;
  tx_state_e         tx_state_q, tx_state_d;
  logic [BEAT_W-1:0] tx_beat_q, tx_beat_d;
  logic [PKT_W-1:0]  tx_shift_q, tx_shift_d;
  logic              tx_gap_q, tx_gap_d;
  logic              put_q, put_d;
  logic [FLIT_W-1:0] payload_q, payload_d;

  logic [PKT_W-1:0]  rx_mem_q [RXQ_DEPTH];
  logic [RXP_W-1:0]  rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [RXC_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic              rx_push, rx_pop, rx_free;
  logic [PKT_W-1:0]  rx_word;
  rx_state_e         rx_state_q, rx_state_d;
  logic [BEAT_W-1:0] rx_beat_q, rx_beat_d;
  logic [PKT_W-1:0]  rx_asm_q, rx_asm_d;

  logic [CNT_W-1:0]  tx_count_q, tx_count_d;
  logic [CNT_W-1:0]  rx_count_q, rx_count_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  assign tx_full = (tx_cnt_q == TX_FULL);
  assign tx_push = pkt_in_avail && !tx_full;
  assign tx_head = tx_mem_q[tx_rd_q];

  always_comb begin
    tx_wr_d = tx_wr_q;
    tx_rd_d = tx_rd_q;
    tx_cnt_d = tx_cnt_q;
    drop_d = drop_q;
    if (tx_push) begin
      tx_wr_d = (tx_wr_q == TX_LAST) ? {TXP_W{1'b0}} : tx_wr_q + TXP_W'(1);
    end else begin
      tx_wr_d = tx_wr_q;
    end
    if (tx_pop) begin
      tx_rd_d = (tx_rd_q == TX_LAST) ? {TXP_W{1'b0}} : tx_rd_q + TXP_W'(1);
    end else begin
      tx_rd_d = tx_rd_q;
    end
    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + TXC_W'(1);
      2'b01:   tx_cnt_d = tx_cnt_q - TXC_W'(1);
      default: tx_cnt_d = tx_cnt_q;
    endcase
    if (pkt_in_avail && tx_full) begin
      drop_d = drop_q + CNT_W'(1);
    end else begin
      drop_d = drop_q;
    end
  end

  // The gap flag holds IDLE for one cycle after a packet, spacing starts NBEATS+1 apart.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_beat_d  = tx_beat_q;
    tx_shift_d = tx_shift_q;
    tx_gap_d   = 1'b0;
    tx_pop     = 1'b0;
    put_d      = 1'b0;
    payload_d  = {FLIT_W{1'b0}};
    tx_count_d = tx_count_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (!tx_gap_q && (tx_cnt_q != {TXC_W{1'b0}}) && free_outbound) begin
          put_d      = 1'b1;
          payload_d  = tx_head[PKT_W-1 -: FLIT_W];
          tx_shift_d = tx_head << FLIT_W;
          tx_beat_d  = BEAT_W'(1);
          tx_state_d = TX_SEND;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      TX_SEND: begin
        payload_d  = tx_shift_q[PKT_W-1 -: FLIT_W];
        tx_shift_d = tx_shift_q << FLIT_W;
        if (tx_beat_q == LAST_BEAT) begin
          tx_pop     = 1'b1;
          tx_gap_d   = 1'b1;
          tx_beat_d  = {BEAT_W{1'b0}};
          tx_count_d = tx_count_q + CNT_W'(1);
          tx_state_d = TX_IDLE;
        end else begin
          tx_beat_d  = tx_beat_q + BEAT_W'(1);
        end
      end
      default: begin
        tx_beat_d  = {BEAT_W{1'b0}};
        tx_state_d = TX_IDLE;
      end
    endcase
  end

  assign rx_free = (rx_state_q == RX_IDLE) && (rx_cnt_q < RX_FULL);
  assign rx_pop  = (rx_cnt_q != {RXC_W{1'b0}}) && pkt_out_ready;
  assign rx_word = {rx_asm_q[PKT_W-FLIT_W-1:0], payload_inbound};

  // Receive: space was reserved at packet start, so the final push cannot overflow.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_beat_d  = rx_beat_q;
    rx_asm_d   = rx_asm_q;
    rx_push    = 1'b0;
    rx_count_d = rx_count_q;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_free && put_inbound) begin
          rx_asm_d   = rx_word;
          rx_beat_d  = BEAT_W'(1);
          rx_state_d = RX_RECV;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_RECV: begin
        rx_asm_d = rx_word;
        if (rx_beat_q == LAST_BEAT) begin
          rx_push    = 1'b1;
          rx_beat_d  = {BEAT_W{1'b0}};
          rx_count_d = rx_count_q + CNT_W'(1);
          rx_state_d = RX_IDLE;
        end else begin
          rx_beat_d  = rx_beat_q + BEAT_W'(1);
        end
      end
      default: begin
        rx_beat_d  = {BEAT_W{1'b0}};
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  always_comb begin
    rx_wr_d = rx_wr_q;
    rx_rd_d = rx_rd_q;
    rx_cnt_d = rx_cnt_q;
    if (rx_push) begin
      rx_wr_d = (rx_wr_q == RX_LAST) ? {RXP_W{1'b0}} : rx_wr_q + RXP_W'(1);
    end else begin
      rx_wr_d = rx_wr_q;
    end
    if (rx_pop) begin
      rx_rd_d = (rx_rd_q == RX_LAST) ? {RXP_W{1'b0}} : rx_rd_q + RXP_W'(1);
    end else begin
      rx_rd_d = rx_rd_q;
    end
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + RXC_W'(1);
      2'b01:   rx_cnt_d = rx_cnt_q - RXC_W'(1);
      default: rx_cnt_d = rx_cnt_q;
    endcase
  end

  // Queue storage needs no reset: pointers and counts define what is valid.
  always_ff @(posedge clock) begin
    if (tx_push) begin
      tx_mem_q[tx_wr_q] <= pkt_in;
    end
    if (rx_push) begin
      rx_mem_q[rx_wr_q] <= rx_word;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_wr_q    <= {TXP_W{1'b0}};
      tx_rd_q    <= {TXP_W{1'b0}};
      tx_cnt_q   <= {TXC_W{1'b0}};
      tx_state_q <= TX_IDLE;
      tx_beat_q  <= {BEAT_W{1'b0}};
      tx_shift_q <= {PKT_W{1'b0}};
      tx_gap_q   <= 1'b0;
      put_q      <= 1'b0;
      payload_q  <= {FLIT_W{1'b0}};
      rx_wr_q    <= {RXP_W{1'b0}};
      rx_rd_q    <= {RXP_W{1'b0}};
      rx_cnt_q   <= {RXC_W{1'b0}};
      rx_state_q <= RX_IDLE;
      rx_beat_q  <= {BEAT_W{1'b0}};
      rx_asm_q   <= {PKT_W{1'b0}};
      tx_count_q <= {CNT_W{1'b0}};
      rx_count_q <= {CNT_W{1'b0}};
      drop_q     <= {CNT_W{1'b0}};
    end else begin
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_state_q <= tx_state_d;
      tx_beat_q  <= tx_beat_d;
      tx_shift_q <= tx_shift_d;
      tx_gap_q   <= tx_gap_d;
      put_q      <= put_d;
      payload_q  <= payload_d;
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_state_q <= rx_state_d;
      rx_beat_q  <= rx_beat_d;
      rx_asm_q   <= rx_asm_d;
      tx_count_q <= tx_count_d;
      rx_count_q <= rx_count_d;
      drop_q     <= drop_d;
    end
  end

  assign cQ_full          = tx_full;
  assign pkt_out_avail    = (rx_cnt_q != {RXC_W{1'b0}});
  assign pkt_out          = pkt_out_avail ? rx_mem_q[rx_rd_q] : {PKT_W{1'b0}};
  assign put_outbound     = put_q;
  assign payload_outbound = payload_q;
  assign free_inbound     = rx_free;
  assign tx_pkt_count     = tx_count_q;
  assign rx_pkt_count     = rx_count_q;
  assign drop_count       = drop_q;

endmodule
